crc_parallel: RTL and testbench

- Parametrised successor to the team's bit-serial CRC generator. Consumes DATA_W bits per clock, MSB first, under a valid/ready handshake.
- Frames are delimited by in_last. At frame end the block presents the finished CRC and frame beat count on an output valid/ready handshake.
- Direct (non-augmented) algorithm: the caller never zero-pads. Configurable init value and final XOR.
- Sits between a byte/word stream source and the framer or checker that appends or compares the CRC.

---
 rtl/crc_parallel_if.sv | 38 +++
 rtl/crc_parallel.sv | 122 ++++++++++++
 tb/tb_crc_parallel.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_parallel_if.sv
// Beat stream in, finished CRC + beat count out, both on valid/ready.
// crc_match is present only when CRC_CHECK_EN is defined.
interface crc_parallel_if #(
  parameter int DATA_W  = 8,
  parameter int CRC_LEN = 16,
  parameter int LEN_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               in_last;
  logic               in_abort;
  logic               crc_valid;
  logic               crc_ready;
  logic [CRC_LEN-1:0] crc_out;
  logic [LEN_W-1:0]   len_out;
`ifdef CRC_CHECK_EN
  logic               crc_match;
`endif

  // master: the stream source / result consumer side
  modport master (
    output in_valid, in_data, in_last, in_abort, crc_ready,
    input  in_ready, crc_valid, crc_out, len_out
`ifdef CRC_CHECK_EN
    , input crc_match
`endif
  );

  // slave: the CRC engine
  modport slave (
    input  in_valid, in_data, in_last, in_abort, crc_ready,
    output in_ready, crc_valid, crc_out, len_out
`ifdef CRC_CHECK_EN
    , output crc_match
`endif
  );
endinterface

// File: rtl/crc_parallel.sv
// Parallel MSB-first CRC over DATA_W bits/beat; CRC_CHECK_EN adds residue check (crc_match).
// Latency: crc_valid rises the cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a result is held; it waits for crc_ready, never dropped.
module crc_parallel #(
  parameter int                 CRC_LEN        = 16,
  parameter logic [CRC_LEN-1:0] CRC_POLYNOMIAL = 16'h8005,
  parameter int                 DATA_W         = 8,
  parameter logic [CRC_LEN-1:0] CRC_INIT       = '0,
  parameter logic [CRC_LEN-1:0] XOR_OUT        = '0,
  parameter int                 LEN_W          = 16
`ifdef CRC_CHECK_EN
  , parameter logic [CRC_LEN-1:0] CHECK_RESIDUE = '0
`endif
) (
  input logic          clk_in,
  input logic          reset,
  crc_parallel_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [CRC_LEN-1:0] crc_reg;
  logic [CRC_LEN-1:0] crc_next;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic               crc_valid_r;
  logic [CRC_LEN-1:0] crc_out_r;
  logic [LEN_W-1:0]   len_out_r;
`ifdef CRC_CHECK_EN
  logic               crc_match_r;
`endif

  // DATA_W serial steps unrolled into one combinational cone
  function automatic logic [CRC_LEN-1:0] crc_advance(
    input logic [CRC_LEN-1:0] c,
    input logic [DATA_W-1:0]  d
  );
    logic [CRC_LEN-1:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r[CRC_LEN-1] ^ d[i]) begin
        r = {r[CRC_LEN-2:0], 1'b0} ^ CRC_POLYNOMIAL;
      end else begin
        r = {r[CRC_LEN-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  always_comb begin
    crc_next = crc_advance(crc_reg, io.in_data);
  end

  assign cnt_inc = (beat_cnt == {LEN_W{1'b1}}) ? beat_cnt : beat_cnt + LEN_W'(1);

  assign io.in_ready  = (state != HOLD);
  assign io.crc_valid = crc_valid_r;
  assign io.crc_out   = crc_out_r;
  assign io.len_out   = len_out_r;
`ifdef CRC_CHECK_EN
  assign io.crc_match = crc_match_r;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      crc_reg     <= CRC_INIT;
      beat_cnt    <= '0;
      crc_valid_r <= 1'b0;
      crc_out_r   <= '0;
      len_out_r   <= '0;
`ifdef CRC_CHECK_EN
      crc_match_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, RUN: begin
          // abort wins over any beat presented in the same cycle
          if (io.in_abort) begin
            state    <= IDLE;
            crc_reg  <= CRC_INIT;
            beat_cnt <= '0;
          end else if (io.in_valid) begin
            crc_reg  <= crc_next;
            beat_cnt <= cnt_inc;
            if (io.in_last) begin
              state       <= HOLD;
              crc_valid_r <= 1'b1;
              crc_out_r   <= crc_next ^ XOR_OUT;
              len_out_r   <= cnt_inc;
`ifdef CRC_CHECK_EN
              crc_match_r <= (crc_next == CHECK_RESIDUE);
`endif
            end else begin
              state <= RUN;
            end
          end
        end
        HOLD: begin
          if (io.crc_ready) begin
            state       <= IDLE;
            crc_valid_r <= 1'b0;
            crc_reg     <= CRC_INIT;
            beat_cnt    <= '0;
`ifdef CRC_CHECK_EN
            crc_match_r <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_parallel.sv
// Directed bench for crc_parallel: reference results come from an augmented serial CRC model and known check values.
module tb_crc_parallel;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [7:0]  frame[$];
  logic [15:0] exp_crc_q[$];
  logic [15:0] exp_crc2_q[$];
  int          exp_len_q[$];
  bit          std_q[$];

  always #5 clk = ~clk;

  crc_parallel_if #(.DATA_W(8), .CRC_LEN(16), .LEN_W(16)) if0 (), if1 (), if2 ();
  crc_parallel_if #(.DATA_W(8), .CRC_LEN(16), .LEN_W(3))  if4 ();
  crc_parallel_if #(.DATA_W(1), .CRC_LEN(16), .LEN_W(16)) if3 ();

  // byte-wide DUTs share one stimulus stream
  assign if1.in_valid = if0.in_valid;  assign if2.in_valid = if0.in_valid;  assign if4.in_valid = if0.in_valid;
  assign if1.in_data  = if0.in_data;   assign if2.in_data  = if0.in_data;   assign if4.in_data  = if0.in_data;
  assign if1.in_last  = if0.in_last;   assign if2.in_last  = if0.in_last;   assign if4.in_last  = if0.in_last;
  assign if1.in_abort = if0.in_abort;  assign if2.in_abort = if0.in_abort;  assign if4.in_abort = if0.in_abort;
  assign if1.crc_ready = if0.crc_ready; assign if2.crc_ready = if0.crc_ready; assign if4.crc_ready = if0.crc_ready;

  crc_parallel dut0 (.clk_in(clk), .reset(rst), .io(if0.slave));
  crc_parallel #(.CRC_POLYNOMIAL(16'h1021), .CRC_INIT(16'hFFFF)) dut1 (.clk_in(clk), .reset(rst), .io(if1.slave));
  crc_parallel #(.CRC_POLYNOMIAL(16'h1021)) dut2 (.clk_in(clk), .reset(rst), .io(if2.slave));
  crc_parallel #(.LEN_W(3)) dut4 (.clk_in(clk), .reset(rst), .io(if4.slave));
  crc_parallel #(.DATA_W(1)) dut3 (.clk_in(clk), .reset(rst), .io(if3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // augmented form: message shifted in, then CRC_LEN zero bits (init 0, no final xor)
  function automatic logic [15:0] aug_crc(input logic [15:0] poly);
    logic [15:0] r;
    logic [7:0]  b;
    logic        top;
    r = '0;
    for (int j = 0; j < frame.size() + 2; j++) begin
      b = (j < frame.size()) ? frame[j] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        top = r[15];
        r   = {r[14:0], b[k]};
        if (top) r = r ^ poly;
      end
    end
    return r;
  endfunction

  task automatic load_std();
    string s;
    s = "123456789";
    frame = {};
    for (int i = 0; i < s.len(); i++) frame.push_back(s[i]);
  endtask

  // drives the frame on if0; with do_last the last beat carries in_last and expectations are queued
  task automatic send_frame(input bit std, input bit do_last);
    if (do_last) begin
      exp_crc_q.push_back(aug_crc(16'h8005));
      exp_crc2_q.push_back(aug_crc(16'h1021));
      exp_len_q.push_back(frame.size());
      std_q.push_back(std);
    end
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      for (int w = 0; w < 20 && !if0.in_ready; w++) @(negedge clk);
      chk("in_ready_beat", if0.in_ready, 1);
      if0.in_valid = 1'b1;
      if0.in_data  = frame[i];
      if0.in_last  = do_last && (i == frame.size() - 1);
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
  endtask

  // called at the first negedge after the last beat: crc_valid must already be up
  task automatic collect();
    logic [15:0] c, c2;
    int          l;
    bit          s;
    c  = exp_crc_q.pop_front();
    c2 = exp_crc2_q.pop_front();
    l  = exp_len_q.pop_front();
    s  = std_q.pop_front();
    chk("crc_valid_latency", if0.crc_valid, 1);
    chk("crc_out", if0.crc_out, c);
    chk("len_out", if0.len_out, l);
    chk("crc_out_1021_init0", if2.crc_out, c2);
    chk("crc_out_lenw3", if4.crc_out, c);
    chk("len_out_sat", if4.len_out, (l > 7) ? 7 : l);
    if (s) begin
      chk("check_8005", if0.crc_out, 16'hFEE8);
      chk("check_1021_ffff", if1.crc_out, 16'h29B1);
      chk("check_1021_0000", if2.crc_out, 16'h31C3);
    end
  endtask

  task automatic handshake();
    if0.crc_ready = 1'b1;
    @(negedge clk);
    if0.crc_ready = 1'b0;
    chk("crc_valid_clear", if0.crc_valid, 0);
    chk("in_ready_after", if0.in_ready, 1);
`ifdef CRC_CHECK_EN
    chk("crc_match_clear", if0.crc_match, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if0.in_valid = 0; if0.in_data = '0; if0.in_last = 0; if0.in_abort = 0; if0.crc_ready = 0;
    if3.in_valid = 0; if3.in_data = '0; if3.in_last = 0; if3.in_abort = 0; if3.crc_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_crc_valid", if0.crc_valid, 0);
    chk("rst_crc_out", if0.crc_out, 0);
    chk("rst_len_out", if0.len_out, 0);
    chk("rst_in_ready", if0.in_ready, 1);
`ifdef CRC_CHECK_EN
    chk("rst_crc_match", if0.crc_match, 0);
`endif
    rst = 1'b0;

    // check string on all byte-wide engines
    load_std();
    send_frame(1, 1);
    collect();
    handshake();

    // result held under backpressure; junk beats and abort ignored in HOLD
    load_std();
    send_frame(1, 1);
    for (int n = 0; n < 5; n++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 8'($urandom);
      if0.in_last  = 1'b1;
      if0.in_abort = (n == 2);
      @(negedge clk);
      chk("hold_valid", if0.crc_valid, 1);
      chk("hold_crc", if0.crc_out, 16'hFEE8);
      chk("hold_ready", if0.in_ready, 0);
    end
    if0.in_valid = 1'b0; if0.in_last = 1'b0; if0.in_abort = 1'b0;
    collect();
    handshake();
    load_std();
    send_frame(1, 1);
    collect();
    handshake();

    // abort mid-frame, beat with in_last in the abort cycle is dropped
    frame = {8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(0, 0);
    if0.in_valid = 1'b1; if0.in_data = 8'h55; if0.in_last = 1'b1; if0.in_abort = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0; if0.in_last = 1'b0; if0.in_abort = 1'b0;
    chk("abort_no_valid", if0.crc_valid, 0);
    load_std();
    send_frame(1, 1);
    collect();
    handshake();

    // reset mid-frame, then reset while holding a result
    frame = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_frame(0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_std();
    send_frame(1, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_valid", if0.crc_valid, 0);
    chk("rst_hold_crc", if0.crc_out, 0);
    void'(exp_crc_q.pop_front()); void'(exp_crc2_q.pop_front());
    void'(exp_len_q.pop_front()); void'(std_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    load_std();
    send_frame(1, 1);
    collect();
    handshake();

    // single-beat frame
    frame = {8'hA5};
    send_frame(0, 1);
    collect();
    handshake();

    // random frames against the model
    for (int f = 0; f < 4; f++) begin
      frame = {};
      for (int i = 0; i < int'($urandom_range(12, 2)); i++) frame.push_back(8'($urandom));
      send_frame(0, 1);
      collect();
      handshake();
    end

`ifdef CRC_CHECK_EN
    load_std();
    frame.push_back(8'hFE);
    frame.push_back(8'hE8);
    send_frame(0, 1);
    collect();
    chk("residue_crc", if0.crc_out, 16'h0000);
    chk("residue_match", if0.crc_match, 1);
    handshake();
    load_std();
    frame.push_back(8'hFE);
    frame.push_back(8'hE9);
    send_frame(0, 1);
    collect();
    chk("corrupt_match", if0.crc_match, 0);
    handshake();
`endif

    // bit-serial engine, same 72 bits MSB first
    load_std();
    for (int j = 0; j < frame.size(); j++) begin
      for (int k = 7; k >= 0; k--) begin
        @(negedge clk);
        chk("serial_in_ready", if3.in_ready, 1);
        if3.in_valid = 1'b1;
        if3.in_data  = frame[j][k];
        if3.in_last  = (j == frame.size() - 1) && (k == 0);
      end
    end
    @(negedge clk);
    if3.in_valid = 1'b0;
    if3.in_last  = 1'b0;
    chk("serial_valid", if3.crc_valid, 1);
    chk("serial_crc", if3.crc_out, 16'hFEE8);
    chk("serial_crc_model", if3.crc_out, aug_crc(16'h8005));
    chk("serial_len", if3.len_out, 72);
    if3.crc_ready = 1'b1;
    @(negedge clk);
    if3.crc_ready = 1'b0;
    chk("serial_clear", if3.crc_valid, 0);

    chk("scoreboard_empty", exp_crc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
